// File: rtl/reg_load_arbiter.sv
// Round-robin arbiter that shares one load-enable register between N_REQ requesters.
// Optional readback check of Q against the written value: define REG_ARB_READBACK_CHECK_EN.
module reg_load_arbiter #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [N_REQ-1:0]         req,
   input  logic [N_REQ*WIDTH-1:0]   req_data,
   input  logic [WIDTH-1:0]         Q,
   output logic [N_REQ-1:0]         gnt,
   output logic                     load,
   output logic [WIDTH-1:0]         D,
   output logic                     busy,
   output logic                     done,
   output logic                     err
);

   localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

`ifdef REG_ARB_READBACK_CHECK_EN
   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CHECK} state_e;
`else
   typedef enum logic [1:0] {S_IDLE, S_LOAD} state_e;
`endif

   state_e               state_q, state_d;
   logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
   logic [PW-1:0]        win_q, win_d;
   logic [WIDTH-1:0]     data_q, data_d;
   logic [N_REQ-1:0]     gnt_q, gnt_d;
   logic                 load_q, load_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
`ifdef REG_ARB_READBACK_CHECK_EN
   logic                 err_q, err_d;
`endif

   logic                 found;
   logic [PW-1:0]        win;
   logic [WIDTH-1:0]     win_data;

   // First set request at or after rr_ptr, wrapping modulo N_REQ.
   always_comb begin
      found    = 1'b0;
      win      = '0;
      win_data = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         int unsigned idx;
         idx = i + 32'(rr_ptr_q);
         if (idx >= N_REQ) idx = idx - N_REQ;
         if (!found && req[idx]) begin
            found    = 1'b1;
            win      = PW'(idx);
            win_data = req_data[idx*WIDTH +: WIDTH];
         end
      end
   end

   // Outputs are computed alongside the next state so they are valid during that state.
   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      win_d    = win_q;
      data_d   = data_q;
      gnt_d    = '0;
      load_d   = 1'b0;
      busy_d   = busy_q;
      done_d   = 1'b0;
`ifdef REG_ARB_READBACK_CHECK_EN
      err_d    = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            busy_d = 1'b0;
            if (found) begin
               win_d      = win;
               data_d     = win_data;
               gnt_d[win] = 1'b1;
               load_d     = 1'b1;
               busy_d     = 1'b1;
               state_d    = S_LOAD;
            end
         end
         S_LOAD: begin
            rr_ptr_d = (win_q == PW'(N_REQ - 1)) ? '0 : win_q + PW'(1);
`ifdef REG_ARB_READBACK_CHECK_EN
            busy_d   = 1'b1;
            state_d  = S_CHECK;
`else
            busy_d   = 1'b0;
            done_d   = 1'b1;
            state_d  = S_IDLE;
`endif
         end
`ifdef REG_ARB_READBACK_CHECK_EN
         S_CHECK: begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            err_d   = (Q != data_q);
            state_d = S_IDLE;
         end
`endif
         default: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         rr_ptr_q <= '0;
         win_q    <= '0;
         data_q   <= '0;
         gnt_q    <= '0;
         load_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
`ifdef REG_ARB_READBACK_CHECK_EN
         err_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         win_q    <= win_d;
         data_q   <= data_d;
         gnt_q    <= gnt_d;
         load_q   <= load_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
`ifdef REG_ARB_READBACK_CHECK_EN
         err_q    <= err_d;
`endif
      end
   end

   assign gnt  = gnt_q;
   assign load = load_q;
   assign D    = data_q;
   assign busy = busy_q;
   assign done = done_q;

`ifdef REG_ARB_READBACK_CHECK_EN
   assign err = err_q;
`else
   logic unused_readback;
   assign unused_readback = ^Q;
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_reg_load_arbiter.sv
// Directed bench for reg_load_arbiter with a behavioural model of the controlled register.
// Works with or without REG_ARB_READBACK_CHECK_EN defined.
module tb_reg_load_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  req;
   logic [31:0] req_data;
   logic [7:0]  Q;
   logic [3:0]  gnt;
   logic        load;
   logic [7:0]  D;
   logic        busy, done, err;

   logic [7:0]  q_reg;
   logic        q_force;
   logic [7:0]  q_force_val;

   int checks = 0;
   int errors = 0;

`ifdef REG_ARB_READBACK_CHECK_EN
   localparam bit RB = 1'b1;
`else
   localparam bit RB = 1'b0;
`endif

   typedef struct {
      logic [3:0]  req;
      logic [31:0] data;
      logic [3:0]  gnt;
      logic [7:0]  d;
   } vec_t;

   vec_t vecs[13];

   reg_load_arbiter #(.N_REQ(4), .WIDTH(8)) dut (
      .clk(clk), .reset(reset), .req(req), .req_data(req_data), .Q(Q),
      .gnt(gnt), .load(load), .D(D), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   // Controlled register model; q_force lets the bench corrupt readback.
   always @(posedge clk or negedge reset)
      if (!reset) q_reg <= 8'h00;
      else if (load) q_reg <= D;
   assign Q = q_force ? q_force_val : q_reg;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk)
      if (reset === 1'b1) check("done_load_exclusive", {31'b0, done & load}, 32'h0);

   task automatic wait_load(output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (load === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic finish_txn(input string tag, input logic [7:0] exp_d, input logic exp_err);
      if (RB) begin
         @(negedge clk);
         check({tag, " check busy"}, {31'b0, busy}, 32'h1);
         check({tag, " check done"}, {31'b0, done}, 32'h0);
         check({tag, " check load"}, {31'b0, load}, 32'h0);
      end
      @(negedge clk);
      check({tag, " done"}, {31'b0, done}, 32'h1);
      check({tag, " load off"}, {31'b0, load}, 32'h0);
      check({tag, " busy off"}, {31'b0, busy}, 32'h0);
      check({tag, " gnt off"}, {28'b0, gnt}, 32'h0);
      check({tag, " err"}, {31'b0, err}, {31'b0, exp_err});
      check({tag, " D hold"}, {24'b0, D}, {24'b0, exp_d});
      check({tag, " Q written"}, {24'b0, q_reg}, {24'b0, exp_d});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not end, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      bit ok;

      vecs[0]  = '{4'b0100, 32'h00AA0000, 4'b0100, 8'hAA};
      vecs[1]  = '{4'b1111, 32'h44332211, 4'b1000, 8'h44};
      vecs[2]  = '{4'b1111, 32'h44332211, 4'b0001, 8'h11};
      vecs[3]  = '{4'b1111, 32'h44332211, 4'b0010, 8'h22};
      vecs[4]  = '{4'b1111, 32'h44332211, 4'b0100, 8'h33};
      vecs[5]  = '{4'b1111, 32'h44332211, 4'b1000, 8'h44};
      vecs[6]  = '{4'b1111, 32'h44332211, 4'b0001, 8'h11};
      vecs[7]  = '{4'b1000, 32'h44332211, 4'b1000, 8'h44};
      vecs[8]  = '{4'b0101, 32'h44332211, 4'b0001, 8'h11};
      vecs[9]  = '{4'b0101, 32'h44332211, 4'b0100, 8'h33};
      vecs[10] = '{4'b0101, 32'h44332211, 4'b0001, 8'h11};
      vecs[11] = '{4'b0010, 32'h00005A00, 4'b0010, 8'h5A};
      vecs[12] = '{4'b0011, 32'h0000A5C3, 4'b0001, 8'hC3};

      reset = 1'b0; req = '0; req_data = '0; q_force = 1'b0; q_force_val = '0;
      repeat (2) @(negedge clk);
      check("reset gnt",  {28'b0, gnt}, 32'h0);
      check("reset load", {31'b0, load}, 32'h0);
      check("reset D",    {24'b0, D}, 32'h0);
      check("reset busy", {31'b0, busy}, 32'h0);
      check("reset done", {31'b0, done}, 32'h0);
      check("reset err",  {31'b0, err}, 32'h0);

      reset = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check("idle busy", {31'b0, busy}, 32'h0);
         check("idle load", {31'b0, load}, 32'h0);
         check("idle gnt",  {28'b0, gnt}, 32'h0);
         check("idle done", {31'b0, done}, 32'h0);
      end

      req = vecs[0].req; req_data = vecs[0].data;
      for (int i = 0; i < 13; i++) begin
         wait_load(ok);
         check($sformatf("v%0d load seen", i), {31'b0, ok}, 32'h1);
         check($sformatf("v%0d gnt", i), {28'b0, gnt}, {28'b0, vecs[i].gnt});
         check($sformatf("v%0d D", i), {24'b0, D}, {24'b0, vecs[i].d});
         check($sformatf("v%0d busy", i), {31'b0, busy}, 32'h1);
         if (i < 12) begin
            req = vecs[i+1].req; req_data = vecs[i+1].data;
         end else begin
            req = '0; req_data = 32'hFFFFFFFF;
         end
         finish_txn($sformatf("v%0d", i), vecs[i].d, 1'b0);
      end

      // Reset asserted while load is high must abort with no done pulse.
      req = 4'b0001; req_data = 32'h00000077;
      wait_load(ok);
      check("abort load seen", {31'b0, ok}, 32'h1);
      check("abort gnt", {28'b0, gnt}, 32'h1);
      reset = 1'b0;
      #1;
      check("abort load async", {31'b0, load}, 32'h0);
      check("abort gnt async",  {28'b0, gnt}, 32'h0);
      check("abort busy async", {31'b0, busy}, 32'h0);
      req = '0;
      @(negedge clk);
      reset = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check("post-abort busy", {31'b0, busy}, 32'h0);
         check("post-abort done", {31'b0, done}, 32'h0);
         check("post-abort load", {31'b0, load}, 32'h0);
      end

      // Readback: corrupted Q flags err with done; correct Q does not.
      req = 4'b0001; req_data = 32'h000000CC;
      wait_load(ok);
      check("rb1 load seen", {31'b0, ok}, 32'h1);
      check("rb1 D", {24'b0, D}, 32'hCC);
      req = '0; q_force = 1'b1; q_force_val = 8'h00;
      finish_txn("rb bad", 8'hCC, RB);
      q_force = 1'b0;

      req = 4'b0001;
      wait_load(ok);
      check("rb2 load seen", {31'b0, ok}, 32'h1);
      check("rb2 gnt", {28'b0, gnt}, 32'h1);
      req = '0;
      finish_txn("rb good", 8'hCC, 1'b0);

      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
